// File: rtl/store_buffer_if.sv
// Data-memory bus between the store buffer (master) and memory (slave).
// Ports: mem_req/mem_we/mem_addr/mem_wdata out of master; mem_ack/mem_rdata back.
interface store_buffer_if #(
   parameter int n = 32
);
   logic         mem_req;
   logic         mem_we;
   logic [n-1:0] mem_addr;
   logic [n-1:0] mem_wdata;
   logic         mem_ack;
   logic [n-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer: stores retire into a FIFO and drain to the bus;
// loads forward from the FIFO or stall on a miss until memory returns data.
// Ports: clk, reset (sync, high); core side memwrite/memread/addr/wdata in,
// rdata/stall/count out; bus = store_buffer_if.master.
module store_buffer #(
   parameter int n     = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   memwrite,
   input  logic                   memread,
   input  logic [n-1:0]           addr,
   input  logic [n-1:0]           wdata,
   output logic [n-1:0]           rdata,
   output logic                   stall,
   output logic [$clog2(DEPTH):0] count,
   store_buffer_if.master         bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int AW = n - 2;

   typedef enum logic [1:0] {IDLE, WRITE, READ, LDONE} state_t;

   state_t        r_state, w_nstate;
   logic [AW-1:0] r_fa [DEPTH];
   logic [n-1:0]  r_fd [DEPTH];
   logic [PW-1:0] r_wp, r_rp;
   logic [CW-1:0] r_cnt;
   logic          r_req, r_we;
   logic [n-1:0]  r_maddr, r_mwdata, r_ld, r_rhold;

   logic          w_req, w_we;
   logic [n-1:0]  w_maddr, w_mwdata;
   logic          w_store, w_load, w_full, w_enq, w_deq;
   logic          w_match, w_hit, w_miss;
   logic [n-1:0]  w_fwd, w_ha, w_hd, w_nha, w_nhd, w_laddr;
   logic [CW-1:0] w_ncnt;
   logic [PW-1:0] w_rp1;
   logic          w_unused;

   assign w_unused = ^addr[1:0];

   assign w_store = memwrite;
   assign w_load  = memread & ~memwrite;
   assign w_full  = (r_cnt == CW'(DEPTH));
   assign w_enq   = w_store & ~w_full;
   assign w_deq   = (r_state == WRITE) & bus.mem_ack;
   assign w_ncnt  = r_cnt + CW'(w_enq) - CW'(w_deq);
   assign w_rp1   = r_rp + 1'b1;
   assign w_laddr = {addr[n-1:2], 2'b00};

   // Head entry, and the head after a dequeue; with one entry left the
   // new head is the store arriving this same cycle.
   assign w_ha  = {r_fa[r_rp], 2'b00};
   assign w_hd  = r_fd[r_rp];
   assign w_nha = (r_cnt > CW'(1)) ? {r_fa[w_rp1], 2'b00} : w_laddr;
   assign w_nhd = (r_cnt > CW'(1)) ? r_fd[w_rp1] : wdata;

   // Scan oldest to youngest so the last match wins.
   always_comb begin
      w_match = 1'b0;
      w_fwd   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (CW'(k) < r_cnt &&
             r_fa[r_rp + PW'(k)] == addr[n-1:2]) begin
            w_match = 1'b1;
            w_fwd   = r_fd[r_rp + PW'(k)];
         end
      end
   end

   assign w_hit  = w_load & w_match;
   assign w_miss = w_load & ~w_match & (r_state != LDONE);
   assign stall  = (w_store & w_full) | w_miss;
   assign count  = r_cnt;

   always_comb begin
      rdata = r_rhold;
      if (r_state == LDONE) rdata = r_ld;
      else if (w_hit)       rdata = w_fwd;
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nstate;
   end

   always_comb begin
      w_nstate = r_state;
      case (r_state)
         IDLE: begin
            if (w_miss)                w_nstate = READ;
            else if (r_cnt != '0)      w_nstate = WRITE;
         end
         WRITE: begin
            if (bus.mem_ack) begin
               if (w_miss)             w_nstate = READ;
               else if (w_ncnt != '0)  w_nstate = WRITE;
               else                    w_nstate = IDLE;
            end
         end
         READ:  if (bus.mem_ack)       w_nstate = LDONE;
         LDONE:                        w_nstate = IDLE;
         default:                      w_nstate = IDLE;
      endcase
   end

   // Next values of the registered bus outputs.
   always_comb begin
      w_req    = r_req;
      w_we     = r_we;
      w_maddr  = r_maddr;
      w_mwdata = r_mwdata;
      case (r_state)
         IDLE: begin
            if (w_miss) begin
               w_req   = 1'b1;
               w_we    = 1'b0;
               w_maddr = w_laddr;
            end else if (r_cnt != '0) begin
               w_req    = 1'b1;
               w_we     = 1'b1;
               w_maddr  = w_ha;
               w_mwdata = w_hd;
            end
         end
         WRITE: begin
            if (bus.mem_ack) begin
               if (w_miss) begin
                  w_we    = 1'b0;
                  w_maddr = w_laddr;
               end else if (w_ncnt != '0) begin
                  w_maddr  = w_nha;
                  w_mwdata = w_nhd;
               end else begin
                  w_req = 1'b0;
               end
            end
         end
         READ:    if (bus.mem_ack) w_req = 1'b0;
         default: w_req = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_req    <= 1'b0;
         r_we     <= 1'b0;
         r_maddr  <= '0;
         r_mwdata <= '0;
         r_wp     <= '0;
         r_rp     <= '0;
         r_cnt    <= '0;
         r_ld     <= '0;
         r_rhold  <= '0;
      end else begin
         r_req    <= w_req;
         r_we     <= w_we;
         r_maddr  <= w_maddr;
         r_mwdata <= w_mwdata;
         r_cnt    <= w_ncnt;
         r_rhold  <= rdata;
         if (w_enq) r_wp <= r_wp + 1'b1;
         if (w_deq) r_rp <= w_rp1;
         if (r_state == READ && bus.mem_ack)
            r_ld <= bus.mem_rdata;
      end
   end

   // Entry storage needs no reset; validity comes from the count.
   always_ff @(posedge clk) begin
      if (!reset && w_enq) begin
         r_fa[r_wp] <= addr[n-1:2];
         r_fd[r_wp] <= wdata;
      end
   end

   assign bus.mem_req   = r_req;
   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = r_maddr;
   assign bus.mem_wdata = r_mwdata;
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: directed core traffic, a bus
// responder with programmable wait/ack budget, and decoupled monitors.
module tb_store_buffer;
   logic        clk;
   logic        reset;
   logic        memwrite;
   logic        memread;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic [2:0]  count;

   store_buffer_if #(.n(32)) bus ();

   store_buffer #(.n(32), .DEPTH(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .memwrite (memwrite),
      .memread  (memread),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .stall    (stall),
      .count    (count),
      .bus      (bus)
   );

   typedef struct {
      bit          we;
      logic [31:0] a;
      logic [31:0] d;
   } bus_t;

   bus_t        exp_bus[$];
   logic [31:0] exp_ld[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          budget = 0;
   int          ack_wait = 0;
   bit          late_ack = 0;
   logic [31:0] rd_val = 32'hCAFEF00D;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit hit, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // Memory responder: acks after ack_wait cycles while budget lasts.
   initial begin
      int w;
      w = 0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         bus.mem_ack = 1'b0;
         if (late_ack) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'h5555AAAA;
            late_ack      = 1'b0;
            w             = 0;
         end else if (bus.mem_req && budget > 0) begin
            if (w >= ack_wait) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = rd_val;
               budget--;
               w = 0;
            end else begin
               w++;
            end
         end else begin
            w = 0;
         end
      end
   end

   // Monitor: completed bus transactions and consumed loads.
   initial begin
      bus_t        e;
      logic [31:0] ev;
      forever begin
         @(negedge clk);
         #1;
         if (bus.mem_req && bus.mem_ack) begin
            if (exp_bus.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL bus_extra: got addr %h, required none",
                        bus.mem_addr);
            end else begin
               e = exp_bus.pop_front();
               chk("bus_we", 32'(bus.mem_we), 32'(e.we));
               chk("bus_addr", bus.mem_addr, e.a);
               if (e.we) chk("bus_wdata", bus.mem_wdata, e.d);
            end
         end
         if (memread && !memwrite && !stall && !reset) begin
            if (exp_ld.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL load_extra: got %h, required none",
                        rdata);
            end else begin
               ev = exp_ld.pop_front();
               chk("load_rdata", rdata, ev);
            end
         end
      end
   end

   function automatic bus_t bw(input logic [31:0] a,
                               input logic [31:0] d);
      bus_t t;
      t.we = 1'b1;
      t.a  = a;
      t.d  = d;
      return t;
   endfunction

   function automatic bus_t br(input logic [31:0] a);
      bus_t t;
      t.we = 1'b0;
      t.a  = a;
      t.d  = '0;
      return t;
   endfunction

   task automatic st(input logic [31:0] a, input logic [31:0] d);
      memwrite = 1'b1;
      memread  = 1'b0;
      addr     = a;
      wdata    = d;
      #1;
      for (int i = 0; i < 100 && stall; i++) begin
         @(negedge clk);
         #1;
      end
      if (stall) begin
         n_vec++;
         n_err++;
         $display("FAIL store_timeout: stall got 1, required 0");
      end
      @(negedge clk);
      memwrite = 1'b0;
   endtask

   task automatic ld(input logic [31:0] a, input logic [31:0] ev,
                     input logic st0);
      exp_ld.push_back(ev);
      memread  = 1'b1;
      memwrite = 1'b0;
      addr     = a;
      #1;
      chk("load_stall_first", 32'(stall), 32'(st0));
      for (int i = 0; i < 100 && stall; i++) begin
         @(negedge clk);
         #1;
      end
      if (stall) begin
         n_vec++;
         n_err++;
         $display("FAIL load_timeout: stall got 1, required 0");
      end
      chk("load_data", rdata, ev);
      @(negedge clk);
      memread = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && (count != 0 || bus.mem_req); i++) begin
         @(negedge clk);
         #1;
      end
      chk("drain_count", 32'(count), 0);
      chk("drain_req", 32'(bus.mem_req), 0);
      @(negedge clk);
   endtask

   initial begin
      reset    = 1'b1;
      memwrite = 1'b0;
      memread  = 1'b0;
      addr     = '0;
      wdata    = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_req", 32'(bus.mem_req), 0);
      chk("rst_we", 32'(bus.mem_we), 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      chk("rst_rdata", rdata, 0);
      @(negedge clk);
      reset = 1'b0;

      // Single store, three wait cycles.
      budget   = 100;
      ack_wait = 3;
      exp_bus.push_back(bw(32'h100, 32'hDEADBEEF));
      memwrite = 1'b1;
      addr     = 32'h100;
      wdata    = 32'hDEADBEEF;
      #1;
      chk("t1_stall", 32'(stall), 0);
      @(negedge clk);
      memwrite = 1'b0;
      #1;
      chk("t1_count", 32'(count), 1);
      @(negedge clk);
      #1;
      chk("t1_req", 32'(bus.mem_req), 1);
      chk("t1_we", 32'(bus.mem_we), 1);
      chk("t1_addr", bus.mem_addr, 32'h100);
      chk("t1_wdata", bus.mem_wdata, 32'hDEADBEEF);
      for (int i = 0; i < 50 && !bus.mem_ack; i++) begin
         @(negedge clk);
         #1;
      end
      chk("t1_ack_seen", 32'(bus.mem_ack), 1);
      @(negedge clk);
      #1;
      chk("t1_count0", 32'(count), 0);
      chk("t1_req0", 32'(bus.mem_req), 0);
      @(negedge clk);

      // Forwarding from the youngest matching entry.
      budget   = 0;
      ack_wait = 0;
      exp_bus.push_back(bw(32'h10, 32'h1));
      exp_bus.push_back(bw(32'h10, 32'h2));
      st(32'h10, 32'h1);
      st(32'h10, 32'h2);
      ld(32'h12, 32'h2, 1'b0);
      #1;
      chk("t2_no_read", 32'(bus.mem_we), 1);
      chk("t2_head_addr", bus.mem_addr, 32'h10);
      budget = 100;
      drain();

      // Full FIFO, then one ack frees a slot.
      budget = 0;
      for (int i = 0; i < 5; i++)
         exp_bus.push_back(bw(32'h300 + 32'(4 * i), 32'h30 + 32'(i)));
      for (int i = 0; i < 4; i++)
         st(32'h300 + 32'(4 * i), 32'h30 + 32'(i));
      memwrite = 1'b1;
      addr     = 32'h310;
      wdata    = 32'h34;
      #1;
      chk("t3_full_stall", 32'(stall), 1);
      chk("t3_full_count", 32'(count), 4);
      budget = 1;
      @(negedge clk);
      #1;
      chk("t3_deq_cycle_stall", 32'(stall), 1);
      @(negedge clk);
      #1;
      chk("t3_after_stall", 32'(stall), 0);
      chk("t3_after_count", 32'(count), 3);
      @(negedge clk);
      memwrite = 1'b0;
      #1;
      chk("t3_refill_count", 32'(count), 4);
      budget = 100;
      drain();

      // Load miss behind an in-flight write.
      budget   = 100;
      ack_wait = 2;
      exp_bus.push_back(bw(32'h400, 32'hA));
      exp_bus.push_back(br(32'h200));
      exp_bus.push_back(bw(32'h404, 32'hB));
      st(32'h400, 32'hA);
      st(32'h404, 32'hB);
      ld(32'h200, 32'hCAFEF00D, 1'b1);
      #1;
      chk("t4_count_left", 32'(count), 1);
      drain();

      // Ten stores, ack every cycle, pointers wrap.
      budget   = 100;
      ack_wait = 0;
      for (int i = 0; i < 10; i++)
         exp_bus.push_back(bw(32'h500 + 32'(4 * i), 32'h1000 + 32'(i)));
      for (int i = 0; i < 10; i++)
         st(32'h500 + 32'(4 * i), 32'h1000 + 32'(i));
      drain();

      // Reset in READ, then a stray ack.
      budget  = 0;
      memread = 1'b1;
      addr    = 32'h600;
      @(negedge clk);
      #1;
      chk("t6_req", 32'(bus.mem_req), 1);
      chk("t6_we", 32'(bus.mem_we), 0);
      chk("t6_addr", bus.mem_addr, 32'h600);
      chk("t6_stall", 32'(stall), 1);
      @(negedge clk);
      reset   = 1'b1;
      memread = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t6_rst_req", 32'(bus.mem_req), 0);
      chk("t6_rst_stall", 32'(stall), 0);
      chk("t6_rst_count", 32'(count), 0);
      late_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("t6_late_req", 32'(bus.mem_req), 0);
      chk("t6_late_stall", 32'(stall), 0);
      chk("t6_late_count", 32'(count), 0);
      chk("t6_late_rdata", rdata, 0);
      @(negedge clk);

      // Still functional after the abandoned read.
      budget = 100;
      exp_bus.push_back(bw(32'h700, 32'h77));
      st(32'h700, 32'h77);
      drain();

      repeat (3) @(negedge clk);
      chk("bus_queue_empty", 32'(exp_bus.size()), 0);
      chk("load_queue_empty", 32'(exp_ld.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the CPU datapath's data-memory port (ALU result as address, register read data as store data, load data back) and a slower handshaked data-memory bus.
- Stores retire in one cycle into a FIFO and drain to memory in the background.
- Loads hitting a buffered address are forwarded from the FIFO. Loads that miss stall the core until memory returns data.

Parameters:
- n, 32, data and address width
- DEPTH, 4, FIFO entries (power of 2, at least 2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- memwrite  in  1  core store request
- memread  in  1  core load request
- addr  in  n  core byte address; bits [1:0] ignored (word access only)
- wdata  in  n  core store data
- rdata  out  n  load data to core
- stall  out  1  core must hold its current instruction and PC
- count  out  $clog2(DEPTH)+1  current FIFO occupancy
- mem_req  out  1  bus request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  n  bus word address (byte address, bits [1:0] = 0)
- mem_wdata  out  n  bus write data
- mem_ack  in  1  one-cycle completion pulse from memory
- mem_rdata  in  n  read data, valid when mem_ack=1 and mem_we=0

Behaviour:
- Reset:
  - count=0; FIFO emptied, entries discarded.
  - state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, stall=0.
  - Reset mid-transaction abandons it: mem_req drops the next cycle, and any mem_ack after reset is ignored.
- Compare rule: address matching compares addr[n-1:2] only.
- Stores (memwrite=1, memread=0):
  - If count<DEPTH: entry {addr[n-1:2], wdata} is enqueued at the clock edge, stall=0.
  - If count==DEPTH: stall=1 (combinational) and nothing is enqueued.
  - Full is judged on registered count. No enqueue is accepted on the cycle a dequeue frees space; the store is accepted one cycle later.
- Load forwarding (memread=1, memwrite=0):
  - If any valid entry matches, rdata = data of the youngest matching entry, combinationally.
  - stall=0; no bus access.
- Load miss: stall=1 until the load data is registered (see FSM). Missed loads may bypass older buffered stores, because none match.
- memread and memwrite both 1: treated as a store; memread ignored.
- Bus handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered.
  - They are held stable from assertion until the cycle mem_ack=1.
  - mem_req deasserts on the cycle after mem_ack.
  - Any number of wait cycles is permitted.
- FSM states IDLE, WRITE, READ, LDONE:
  - IDLE: a load miss goes to READ (issue read, mem_we=0, addr=miss address). Otherwise, if count>0, go to WRITE (issue write of head entry, mem_we=1). Otherwise stay. A load miss takes priority over draining.
  - WRITE: on mem_ack, dequeue head and count--. Then go to READ if a load miss is present, else WRITE if entries remain (next head issued without an idle cycle), else IDLE. An in-flight write is never aborted by a load.
  - READ: on mem_ack, capture mem_rdata into a load register and go to LDONE. stall=1 throughout.
  - LDONE: rdata = load register, stall=0, return to IDLE. The core consumes the load this cycle.
- Simultaneous enqueue and dequeue: count unchanged, pointers both advance.
- Pointer wrap: read/write pointers wrap modulo DEPTH; FIFO order is preserved across wrap.
- When no forwarding and not in LDONE: rdata holds its last value (not X).

Test Plan:
- Reset, then a store to 0x100 with data 0xDEADBEEF -> stall=0, count=1. Next cycle mem_req=1, mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF. With ack after 3 wait cycles, count=0 and mem_req=0 the cycle after ack.
- Stores to 0x10 (0x1), then 0x10 (0x2), then a load from 0x12, with memory never acking -> rdata=0x00000002 the same cycle, stall=0, no read issued.
- Bus not acking, 5 consecutive stores with DEPTH=4 -> count reaches 4 and stall=1 on the 5th store. After one ack, the 5th store is accepted the following cycle, count=4. Drain order on the bus matches issue order.
- Load miss from 0x200 while a write is in flight -> write completes first. Then a read is issued to 0x200. On ack with mem_rdata=0xCAFEF00D, the next cycle stall=0 and rdata=0xCAFEF00D. Remaining stores drain afterwards.
- 10 stores to distinct addresses with an ack every cycle -> pointers wrap twice, bus sees all 10 addresses in order, final count=0.
- Reset asserted in READ with mem_req=1 -> next cycle mem_req=0, stall=0, count=0. A late mem_ack is ignored (no state change).
